// File: rtl/mem_trace_pkg.sv
// Shared widths, opcode/state enums and the packed trace record.
// Optional build macro used by trace_responder: TRACE_TIME_GATE_EN.
package mem_trace_pkg;

   localparam int TIME_W  = 12;
   localparam int OP_W    = 12;
   localparam int ADDR_W  = 36;
   localparam int ENTRY_W = TIME_W + OP_W + ADDR_W;

   typedef enum logic [OP_W-1:0] {
      OP_READ   = 12'd0,
      OP_WRITE  = 12'd1,
      OP_IFETCH = 12'd2
   } memop_e;

   typedef struct packed {
      logic [TIME_W-1:0] issue_time;
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] addr;
   } trace_entry_t;

   typedef enum logic {
      S_IDLE,
      S_PRESENT
   } state_e;

   // Opcodes above the last enumerated one are illegal.
   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return op <= OP_IFETCH;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Small power-of-two FIFO with a combinational head read.
// Simultaneous push and pop leave the occupancy unchanged.
module trace_fifo #(
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 60
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] wdata,
   output logic [ENTRY_W-1:0] rdata,
   output logic               full,
   output logic               empty
);

   localparam int AW = $clog2(DEPTH);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;
   logic               do_push;
   logic               do_pop;

   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/trace_responder.sv
// Supply side of the trace-request 4-phase handshake.
// Define TRACE_TIME_GATE_EN to hold each entry until cycle >= its time.
module trace_responder
   import mem_trace_pkg::*;
#(
   parameter int TF_MEMOP_TIME_WIDTH = 12,
   parameter int MEMOP_WIDTH         = 12,
   parameter int ADDR_WIDTH          = 36,
   parameter int DEPTH               = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [63:0]           cycle,
   input  logic                  rec_valid,
   input  logic [TF_MEMOP_TIME_WIDTH-1:0] rec_time,
   input  logic [MEMOP_WIDTH-1:0] rec_op,
   input  logic [ADDR_WIDTH-1:0] rec_addr,
   input  logic                  rec_last,
   output logic                  rec_ready,
   input  logic                  data_req,
   output logic                  data_rdy,
   output logic [TF_MEMOP_TIME_WIDTH+MEMOP_WIDTH+ADDR_WIDTH-1:0] data_read,
   output logic                  trace_done,
   output logic [15:0]           drop_count
);

   localparam int EW = TF_MEMOP_TIME_WIDTH + MEMOP_WIDTH + ADDR_WIDTH;

   state_e          state;
   state_e          state_next;
   logic            full;
   logic            empty;
   logic            accept;
   logic            legal;
   logic            push;
   logic            pop;
   logic            load;
   logic            gate_ok;
   logic            last_seen;
   logic [EW-1:0]   wdata;
   logic [EW-1:0]   head;

   assign rec_ready = !full;
   assign accept    = rec_valid && rec_ready && !last_seen;
   assign legal     = rec_op <= MEMOP_WIDTH'(OP_IFETCH);
   assign push      = accept && legal;
   assign wdata     = {rec_time, rec_op, rec_addr};

   trace_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_W (EW)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

`ifdef TRACE_TIME_GATE_EN
   logic [TF_MEMOP_TIME_WIDTH-1:0] head_time;
   assign head_time = head[EW-1 -: TF_MEMOP_TIME_WIDTH];
   assign gate_ok   = cycle >= 64'(head_time);
`else
   logic unused_cycle;
   assign unused_cycle = ^cycle;
   assign gate_ok      = 1'b1;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE: begin
            if (data_req && !empty && gate_ok) begin
               state_next = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (!data_req) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      data_rdy = 1'b0;
      load     = 1'b0;
      pop      = 1'b0;
      unique case (state)
         S_IDLE: begin
            load = data_req && !empty && gate_ok;
         end
         S_PRESENT: begin
            data_rdy = 1'b1;
            pop      = !data_req;
         end
         default: begin
            data_rdy = 1'b0;
         end
      endcase
   end

   // The head is only popped once the requester releases data_req.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_read  <= '0;
         drop_count <= '0;
         last_seen  <= 1'b0;
         trace_done <= 1'b0;
      end else begin
         if (load) begin
            data_read <= head;
         end
         if (accept && !legal && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
         end
         if (accept && rec_last) begin
            last_seen <= 1'b1;
         end
         if (last_seen && empty && state == S_IDLE) begin
            trace_done <= 1'b1;
         end
      end
   end

endmodule

// File: doc/trace_responder.md
Name: trace_responder

Overview:
- Supply side of the trace-request handshake; the memory controller is the requesting side.
- Accepts parsed trace records from the file-reader front end, validates each opcode and buffers records in a small FIFO.
- Answers each controller `data_req` by presenting one packed {time, op, addr} word on `data_read` with `data_rdy`.
- Signals end-of-trace once the final record has been consumed.

Parameters:
- TF_MEMOP_TIME_WIDTH, 12, width of the record timestamp field in cycles
- MEMOP_WIDTH, 12, width of the memory-op code field
- ADDR_WIDTH, 36, width of the target address field
- DEPTH, 8, FIFO entries; must be a power of 2 and at least 2

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- cycle  in  64  current simulation cycle count (longint)
- rec_valid  in  1  front end offers a record this cycle
- rec_time  in  TF_MEMOP_TIME_WIDTH  record issue time (absolute cycle)
- rec_op  in  MEMOP_WIDTH  record opcode
- rec_addr  in  ADDR_WIDTH  record address
- rec_last  in  1  qualifies the offered record as the final trace record
- rec_ready  out  1  responder can accept a record (= !full)
- data_req  in  1  controller requests one entry
- data_rdy  out  1  data_read valid; held until data_req drops
- data_read  out  TF_MEMOP_TIME_WIDTH+MEMOP_WIDTH+ADDR_WIDTH  packed {time, op, addr}
- trace_done  out  1  sticky end-of-trace flag
- drop_count  out  16  count of records rejected for an illegal opcode

Behaviour:
- Reset (asynchronous, active-high): FIFO empties, FSM enters IDLE. All outputs go to 0 (`data_rdy`, `data_read`, `trace_done`, `drop_count`); `rec_ready` goes to 1. Reset asserted mid-handshake aborts the transfer and loses the FIFO contents.
- Record accept: a record is accepted on a clock edge when `rec_valid && rec_ready`.
  - Legal opcodes are 0 = read, 1 = write, 2 = ifetch; these records are pushed.
  - An opcode greater than 2 is not pushed, and `drop_count` increments, saturating at 16'hFFFF.
  - If `rec_last` is accepted, `last_seen` is latched, even when that record is dropped.
- FIFO:
  - `rec_ready` is combinational: !full.
  - Push and pop on the same edge are both performed and the count is unchanged.
  - Pointers wrap modulo DEPTH.
  - With DEPTH = 8 the count runs 0..8; `rec_ready` = 0 while the count is 8.
- FSM, two states:
  - IDLE: `data_rdy` = 0. If `data_req && !empty` (and the time gate passes when enabled) → PRESENT. On that edge, `data_read` is registered from the FIFO head and `data_rdy` is set to 1. The first word is therefore valid 1 cycle after `data_req` is seen.
  - IDLE with `data_req && empty`: stay in IDLE; `data_rdy` remains 0 and the request is held until data arrives.
  - PRESENT: `data_rdy` = 1 and `data_read` is held stable. On the first edge where `data_req` = 0: pop the head, set `data_rdy` to 0, return to IDLE.
  - The handshake is 4-phase. At least one IDLE cycle separates consecutive transfers.
- Word packing: `data_read` = {time, op, addr}. The time field occupies the MSBs and `addr` is bits [ADDR_WIDTH-1:0]. For the defaults the word is 60 bits.
- trace_done:
  - Sets when `last_seen && empty && state == IDLE`.
  - Sticky until reset.
  - Records offered after `last_seen` are ignored: not pushed, not counted.

Optional Feature:
- Macro: TRACE_TIME_GATE_EN.
- Defined: the IDLE → PRESENT transition additionally requires `cycle >= {zero-extended head.time}`. Until then `data_rdy` stays 0 while `data_req` is held.
- Undefined: no time check; an entry is presented as soon as it is requested and available.

Decomposition:
- Package `mem_trace_pkg`:
  - width localparams
  - ENTRY_W = TF_MEMOP_TIME_WIDTH + MEMOP_WIDTH + ADDR_WIDTH
  - `typedef enum` of opcodes: OP_READ = 0, OP_WRITE = 1, OP_IFETCH = 2
  - packed struct `trace_entry_t` {time, op, addr}
  - FSM state enum {S_IDLE, S_PRESENT}
- Sub-module `trace_fifo`:
  - parameterised by DEPTH and ENTRY_W
  - ports: push, pop, wdata, rdata, full, empty
  - asynchronous active-high reset

Test Plan:
- Push {time 5, op 1, addr 36'h0_0000_1234}, then assert `data_req` → `data_rdy` = 1 one cycle later and `data_read` = {12'd5, 12'd1, 36'h000001234}. Drop `data_req` → `data_rdy` = 0 next cycle and the FIFO is empty.
- Push 9 records back-to-back with `rec_valid` held → `rec_ready` goes to 0 after the 8th. The 9th is accepted only after one pop. Data returns in FIFO order, including across pointer wrap.
- Offer op = 7, then op = 2 → `drop_count` = 1 and only the op = 2 record is delivered.
- Offer a final record with `rec_last` = 1, then drain it → `trace_done` = 1 after the final pop and stays 1. A subsequent `rec_valid` is ignored.
- Assert `data_req` with the FIFO empty for 10 cycles, then push → `data_rdy` rises the cycle after the push. Assert reset during PRESENT → `data_rdy` = 0 immediately, and the FIFO and counters are cleared.
- With TRACE_TIME_GATE_EN defined: push time = 200 at cycle = 150 with `data_req` high → `data_rdy` stays 0 until cycle = 200, then asserts.
